mux_select_controller: RTL and testbench
========================================

Name: mux_select_controller

Overview:
Parametrised successor to the board's simple mux-select logic. Synchronises and debounces N push-buttons plus one override switch, latches a sticky source selection from the highest-index newly pressed button, and forces a fixed override code while the switch is held. Drives the select lines of the video/output mux and emits single-cycle write and change strobes for downstream registers.

Parameters:
NUM_BUTTONS, 5, number of button inputs (1..2**SEL_WIDTH-2)
SEL_WIDTH, 3, width of the select output
DEBOUNCE_CYCLES, 4, consecutive stable cycles before a debounced level flips (>=1)
OVERRIDE_SEL, 7, select code driven while override is active; must be > NUM_BUTTONS

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
buttons  input  NUM_BUTTONS  raw asynchronous button levels, active-high
switch  input  1  raw asynchronous override switch, active-high
out  output  SEL_WIDTH  mux select code
write  output  1  one-cycle pulse on debounced switch rising edge
changed  output  1  one-cycle pulse when the stored selection updates
override_active  output  1  debounced switch level

Behaviour:
- Reset (reset low, asynchronous): synchroniser flops, debounce counters, debounced levels, stored selection, out, write, changed, override_active all 0. Release synchronous to clock.
- Synchroniser: two flops per input (NUM_BUTTONS+1 bits) before any logic.
- Debounce, per input: counter width clog2(DEBOUNCE_CYCLES)+1. If synchronised value == debounced value, counter <= 0. Otherwise counter increments; when counter == DEBOUNCE_CYCLES-1 and still mismatched, debounced value flips and counter clears. Glitch shorter than DEBOUNCE_CYCLES cycles never propagates. DEBOUNCE_CYCLES=1: debounced follows synchroniser with one-cycle delay.
- Edge detect: rise[i] = debounced[i] & ~debounced_prev[i]; same for switch.
- Priority: among rise bits in a cycle, highest index wins; code = index+1. Code 0 = nothing selected (reset state only).
- Stored selection sel: updates only on a rise while debounced switch is low. Held buttons do not retrigger; button releases ignored. Rise on an already-selected button reloads the same code and still pulses changed.
- Simultaneous rises: highest index only; lower ones discarded, not queued.
- Override: while debounced switch high, button rises ignored (sel held, changed stays 0), out = OVERRIDE_SEL. On switch fall, out returns to stored sel the next cycle; a button rising in the same cycle as the switch fall is ignored.
- Outputs registered: out, changed, write, override_active update one cycle after the debounced edge.
- Latency raw button -> out: 2 (sync) + DEBOUNCE_CYCLES + 1 edges; default 7.
- write: exactly one cycle per debounced switch rise; none on fall; none after reset if switch already high at release until debounce completes (then one pulse).
- Reset mid-debounce or mid-override: all state cleared; override ends immediately, out = 0.
- Width: OVERRIDE_SEL and codes truncated/zero-extended to SEL_WIDTH; parameter check (simulation assertion) that NUM_BUTTONS+1 < 2**SEL_WIDTH.

Test Plan:
- Reset then idle, all inputs 0 -> out=0, write=0, changed=0, override_active=0 for 50 cycles.
- buttons=5'b00100 held from cycle 0 (defaults) -> out=3 and changed=1 at edge 7, changed=0 at edge 8, out stays 3 after release.
- buttons=5'b10010 rise same cycle -> out=5, single changed pulse; then buttons[0] pressed alone -> out=1.
- 3-cycle pulse on buttons[2] (DEBOUNCE_CYCLES=4) -> out unchanged, changed never asserted.
- out=2, switch high -> write one cycle, out=7, override_active=1; press buttons[4] during override -> out stays 7; switch low -> out=2, no changed pulse.
- reset asserted during override with out=7 -> out=0 immediately (asynchronous), write=0; after release with switch still high, write pulses once after 2+DEBOUNCE_CYCLES+1 edges.

Source files
------------

// File: rtl/mux_select_controller.sv
// Mux source-select controller: synchronises and debounces buttons plus an override switch,
// keeps a sticky selection from the highest newly pressed button, and forces a code during override.
module mux_select_controller #(
    parameter int unsigned NUM_BUTTONS     = 5,
    parameter int unsigned SEL_WIDTH       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OVERRIDE_SEL    = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   switch,
    output logic [SEL_WIDTH-1:0]   out,
    output logic                   write,
    output logic                   changed,
    output logic                   override_active
);

    localparam int unsigned NUM_IN = NUM_BUTTONS + 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0] OVR_CODE = SEL_WIDTH'(OVERRIDE_SEL);

    // Parameter sanity checks at elaboration
    if (NUM_BUTTONS + 1 >= 2**SEL_WIDTH) begin : g_bad_width
        $error("mux_select_controller: NUM_BUTTONS+1 must be < 2**SEL_WIDTH");
    end
    if (OVERRIDE_SEL <= NUM_BUTTONS) begin : g_bad_override
        $error("mux_select_controller: OVERRIDE_SEL must exceed NUM_BUTTONS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("mux_select_controller: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [NUM_IN-1:0]      sync1;
    logic [NUM_IN-1:0]      sync2;
    logic [NUM_IN-1:0]      deb;
    logic [NUM_IN-1:0]      deb_prev;
    logic [CNT_W-1:0]       cnt [NUM_IN];
    logic [SEL_WIDTH-1:0]   sel;
    logic [SEL_WIDTH-1:0]   code_c;
    logic [NUM_BUTTONS-1:0] rise_c;
    logic                   sw_rise_c;
    logic                   take_c;

    // Two-flop synchroniser; the switch rides in the top bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {switch, buttons};
            sync2 <= sync1;
        end
    end

    // Per-input debounce: flip only after DEBOUNCE_CYCLES consecutive mismatching samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detect and highest-index priority; a switch edge in either direction blocks button takes
    always_comb begin
        rise_c    = deb[NUM_BUTTONS-1:0] & ~deb_prev[NUM_BUTTONS-1:0];
        sw_rise_c = deb[NUM_BUTTONS] & ~deb_prev[NUM_BUTTONS];
        code_c    = '0;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (rise_c[i]) begin
                code_c = SEL_WIDTH'(i + 1);
            end
        end
        take_c = (|rise_c) && !deb[NUM_BUTTONS] && !deb_prev[NUM_BUTTONS];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel             <= '0;
            out             <= '0;
            write           <= 1'b0;
            changed         <= 1'b0;
            override_active <= 1'b0;
        end else begin
            if (take_c) begin
                sel <= code_c;
            end
            if (deb[NUM_BUTTONS]) begin
                out <= OVR_CODE;
            end else if (take_c) begin
                out <= code_c;
            end else begin
                out <= sel;
            end
            write           <= sw_rise_c;
            changed         <= take_c;
            override_active <= deb[NUM_BUTTONS];
        end
    end

endmodule

// File: tb/tb_mux_select_controller.sv
// Bench for mux_select_controller: directed scenarios plus random stimulus against a
// sample-history reference model.
module tb_mux_select_controller;

    localparam int unsigned NB  = 5;
    localparam int unsigned SW  = 3;
    localparam int unsigned D   = 4;
    localparam int unsigned OVR = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] buttons = '0;
    logic          switch = 1'b0;
    logic [SW-1:0] out;
    logic          write;
    logic          changed;
    logic          override_active;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [NB:0]   hist [$];
    logic [NB:0]   mdeb;
    logic [NB:0]   mdeb_prev;
    logic [SW-1:0] msel;
    logic [SW+2:0] mexp;

    mux_select_controller #(
        .NUM_BUTTONS(NB), .SEL_WIDTH(SW), .DEBOUNCE_CYCLES(D), .OVERRIDE_SEL(OVR)
    ) dut (
        .clock(clock), .reset(reset), .buttons(buttons), .switch(switch),
        .out(out), .write(write), .changed(changed), .override_active(override_active)
    );

    always #5 clock = ~clock;

    function automatic logic [SW+2:0] obs();
        return {out, write, changed, override_active};
    endfunction

    function automatic logic hist_bit(input int idx, input int b);
        if (idx < 0) return 1'b0;
        return hist[idx][b];
    endfunction

    // Debounced level becomes v once the last D synchronised samples all equal v
    task automatic model_update();
        logic          sw, swp, chg, v, same;
        logic [NB-1:0] br;
        int            hi;
        sw  = mdeb[NB];
        swp = mdeb_prev[NB];
        br  = mdeb[NB-1:0] & ~mdeb_prev[NB-1:0];
        chg = 1'b0;
        if (!sw && !swp && br != '0) begin
            hi = 0;
            for (int i = 0; i < int'(NB); i++) if (br[i]) hi = i;
            msel = SW'(hi + 1);
            chg  = 1'b1;
        end
        mexp = {sw ? SW'(OVR) : msel, sw & ~swp, chg, sw};
        hist.push_back({switch, buttons});
        mdeb_prev = mdeb;
        for (int b = 0; b <= int'(NB); b++) begin
            v    = hist_bit(hist.size() - 3, b);
            same = 1'b1;
            for (int k = 1; k < int'(D); k++) begin
                if (hist_bit(hist.size() - 3 - k, b) != v) same = 1'b0;
            end
            if (same && v != mdeb[b]) mdeb[b] = v;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_update();
        #1;
    endtask

    task automatic model_clear();
        hist.delete();
        mdeb      = '0;
        mdeb_prev = '0;
        msel      = '0;
        mexp      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        model_clear();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        model_clear();
        buttons = '0;
        switch  = 1'b0;
        repeat (3) step();
        vectors++;
        if (obs() !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), '0);
        end
        reset = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step();
            vectors++;
            if (obs() !== '0 || mexp !== '0) begin
                miscompares++;
                $display("FAIL idle cyc=%0d got=%b model=%b exp=0", c, obs(), mexp);
            end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        buttons = 5'b00100;
        for (int e = 1; e <= 12; e++) begin
            step();
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL press cyc=%0d got=%b exp=%b", e, obs(), mexp);
            end
            if (e == 6 || e == 7 || e == 8) begin
                vectors++;
                if (changed !== (e == 7) || (e >= 7 && out !== 3'd3) || (e == 6 && out !== 3'd0)) begin
                    miscompares++;
                    $display("FAIL press_latency edge=%0d got out=%0d chg=%b", e, out, changed);
                end
            end
        end
        buttons = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL release cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        vectors++;
        if (out !== 3'd3) begin
            miscompares++;
            $display("FAIL release_hold got=%0d exp=3", out);
        end
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        buttons = 5'b10010;
        for (int c = 0; c < 12; c++) begin
            step();
            pulses += int'(changed);
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL simul cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        vectors++;
        if (out !== 3'd5 || pulses != 1) begin
            miscompares++;
            $display("FAIL simul_result got out=%0d pulses=%0d exp out=5 pulses=1", out, pulses);
        end
        buttons = '0;
        repeat (8) step();
        buttons = 5'b00001;
        repeat (12) step();
        buttons = '0;
        vectors++;
        if (out !== 3'd1 || obs() !== mexp) begin
            miscompares++;
            $display("FAIL single_low got out=%0d exp=1", out);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        buttons = 5'b00100;
        repeat (3) begin
            step();
            pulses += int'(changed);
        end
        buttons = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            pulses += int'(changed);
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        vectors++;
        if (out !== 3'd1 || pulses != 0) begin
            miscompares++;
            $display("FAIL glitch_result got out=%0d pulses=%0d exp out=1 pulses=0", out, pulses);
        end
    endtask

    task automatic test_override();
        int writes = 0, chg = 0, wedge = 0;
        buttons = 5'b00010;
        repeat (10) step();
        buttons = '0;
        repeat (10) step();
        vectors++;
        if (out !== 3'd2) begin
            miscompares++;
            $display("FAIL pre_override got out=%0d exp=2", out);
        end
        switch = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (write) begin
                writes++;
                wedge = e;
            end
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL override_on cyc=%0d got=%b exp=%b", e, obs(), mexp);
            end
        end
        vectors++;
        if (writes != 1 || wedge != 7 || out !== 3'd7 || override_active !== 1'b1) begin
            miscompares++;
            $display("FAIL override_entry got writes=%0d edge=%0d out=%0d ovr=%b exp 1/7/7/1",
                     writes, wedge, out, override_active);
        end
        buttons = 5'b10000;
        repeat (10) begin
            step();
            chg += int'(changed);
        end
        buttons = '0;
        repeat (10) begin
            step();
            chg += int'(changed);
        end
        switch = 1'b0;
        writes = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            chg += int'(changed);
            writes += int'(write);
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL override_off cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        vectors++;
        if (out !== 3'd2 || chg != 0 || writes != 0 || override_active !== 1'b0) begin
            miscompares++;
            $display("FAIL override_exit got out=%0d chg=%0d writes=%0d exp out=2 chg=0 writes=0",
                     out, chg, writes);
        end
        // A button rise landing on the same edge as the switch fall is dropped
        switch = 1'b1;
        repeat (12) step();
        switch  = 1'b0;
        buttons = 5'b00001;
        chg = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            chg += int'(changed);
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL fall_collide cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        buttons = '0;
        vectors++;
        if (out !== 3'd2 || chg != 0) begin
            miscompares++;
            $display("FAIL fall_collide_result got out=%0d chg=%0d exp out=2 chg=0", out, chg);
        end
        repeat (8) step();
    endtask

    task automatic test_reset_override();
        int writes = 0, wedge = 0;
        switch = 1'b1;
        repeat (12) step();
        vectors++;
        if (out !== 3'd7) begin
            miscompares++;
            $display("FAIL pre_reset got out=%0d exp=7", out);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs() !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=0", obs());
        end
        repeat (3) step();
        model_clear();
        reset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (write) begin
                writes++;
                wedge = e;
            end
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", e, obs(), mexp);
            end
        end
        vectors++;
        if (writes != 1 || wedge != 7 || out !== 3'd7) begin
            miscompares++;
            $display("FAIL post_reset_write got writes=%0d edge=%0d out=%0d exp 1/7/7", writes, wedge, out);
        end
        switch = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                hold = int'($urandom_range(1, 7));
                if ($urandom_range(0, 2) == 0) buttons = NB'($urandom);
                else if ($urandom_range(0, 1) == 0) buttons = '0;
                if ($urandom_range(0, 5) == 0) switch = ~switch;
            end
            hold--;
            step();
            vectors++;
            if (obs() !== mexp) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, obs(), mexp);
            end
        end
        buttons = '0;
        switch  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_glitch();
        test_override();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
